// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store unit and its data-align helper:
//   RV32I funct3 codes, FSM state encoding, access-size lane masks, and a few
//   small decode functions used by both the control path and the lane logic.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACC_LO = 2'b01,
      ST_ACC_HI = 2'b10,
      ST_RESP   = 2'b11
   } lsu_state_e;

   // funct3[1:0] alone encodes the access size; bit 2 only selects zero-extension.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      logic [3:0] m;
      case (sz)
         F3_B[1:0]: m = MASK_B;
         F3_H[1:0]: m = MASK_H;
         default:   m = MASK_W;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         F3_B[1:0]: n = 3'd1;
         F3_H[1:0]: n = 3'd2;
         default:   n = 3'd4;
      endcase
      return n;
   endfunction

   // An access crosses a word boundary when its last byte lands past lane 3.
   function automatic logic crosses_word(input logic [1:0] sz, input logic [1:0] off);
      return (({1'b0, off} + size_bytes(sz)) > 3'd4);
   endfunction

   // Stores have no unsigned variants, so funct3[2] is illegal on a store.
   function automatic logic illegal_req(input logic we, input logic [2:0] f3);
      logic legal;
      legal = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      return (!legal) || (we && f3[2]);
   endfunction

endpackage

// File: rtl/load_store_unit_data_align.sv
// ---------------------------------------------------------------------------
// load_store_unit_data_align
//   Purely combinational lane logic shared by the load/store paths.
//   Store: shifts LSB-aligned store data and the size mask left by the byte
//   offset across a 64-bit {hi,lo} window; the low word uses the lower half,
//   the following word the upper half.
//   Load: shifts the {hi,lo} read window right by the byte offset, truncates
//   to the access size and sign- or zero-extends.
// Ports
//   funct3     in   3   RV funct3 of the access
//   offset     in   2   byte offset within the word
//   wdata      in   32  store data, LSB-aligned
//   rdata_lo   in   32  read data of the addressed word
//   rdata_hi   in   32  read data of the following word (0 when unused)
//   be_lo      out  4   byte enables for the addressed word
//   be_hi      out  4   byte enables for the following word
//   wdata_lo   out  32  lane-shifted store data, addressed word
//   wdata_hi   out  32  lane-shifted store data, following word
//   load_data  out  32  merged and extended load result
// ---------------------------------------------------------------------------
module load_store_unit_data_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_lo,
   input  logic [31:0] rdata_hi,
   output logic [3:0]  be_lo,
   output logic [3:0]  be_hi,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   output logic [31:0] load_data
);

   logic [4:0]  shamt;
   logic [63:0] wwin;
   logic [7:0]  be_win;
   logic [31:0] rword;

   assign shamt  = {offset, 3'b000};
   assign wwin   = {32'h0, wdata} << shamt;
   assign be_win = {4'h0, size_mask(funct3[1:0])} << offset;
   assign rword  = 32'({rdata_hi, rdata_lo} >> shamt);

   assign wdata_lo = wwin[31:0];
   assign wdata_hi = wwin[63:32];
   assign be_lo    = be_win[3:0];
   assign be_hi    = be_win[7:4];

   always_comb begin
      load_data = rword;
      case (funct3)
         F3_B:    load_data = {{24{rword[7]}}, rword[7:0]};
         F3_H:    load_data = {{16{rword[15]}}, rword[15:0]};
         F3_BU:   load_data = {24'h0, rword[7:0]};
         F3_HU:   load_data = {16'h0, rword[15:0]};
         default: load_data = rword;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Bridges the execute stage to a word-addressed data memory. Takes one
//   RV32I load/store per handshake, drives the memory port with byte enables,
//   splits word-crossing accesses into two word cycles (or rejects them when
//   SPLIT_MISAL=0), and returns a single response held until accepted.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready for a request; memory port quiet
//   ST_ACC_LO | addressed word on the memory port; read data captured
//   ST_ACC_HI | following word (wraps) on the memory port for a split access
//   ST_RESP   | response valid and stable until resp_ready_i
//
// Ports
//   clock_i       in   1   rising-edge clock
//   reset_ni      in   1   asynchronous active-low reset
//   req_valid_i   in   1   request present
//   req_ready_o   out  1   high only in ST_IDLE
//   req_we_i      in   1   1 = store, 0 = load
//   req_funct3_i  in   3   RV funct3 (B/H/W/BU/HU)
//   req_addr_i    in   AW  byte address
//   req_wdata_i   in   DW  store data, LSB-aligned
//   resp_valid_o  out  1   response valid
//   resp_ready_i  in   1   response accepted
//   resp_rdata_o  out  DW  extended load data, 0 for stores/errors
//   resp_err_o    out  1   illegal funct3 or rejected misaligned access
//   mem_addr_o    out  AW-2 word address
//   mem_be_o      out  4   byte-lane enables
//   mem_we_o      out  1   write strobe
//   mem_re_o      out  1   read strobe (read data same cycle)
//   mem_wdata_o   out  DW  lane-shifted store data
//   mem_rdata_i   in   DW  word read data
// ---------------------------------------------------------------------------
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter bit SPLIT_MISAL = 1'b1
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic [ADDR_WIDTH-3:0] mem_addr_o,
   output logic [3:0]            mem_be_o,
   output logic                  mem_we_o,
   output logic                  mem_re_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   lsu_state_e            state;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_lo_q;

   logic                  req_illegal;
   logic                  acc_cross;
   logic [ADDR_WIDTH-3:0] word_hi;

   logic [2:0]            al_funct3;
   logic [1:0]            al_offset;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic [DATA_WIDTH-1:0] al_rdata_lo;
   logic [DATA_WIDTH-1:0] al_rdata_hi;
   logic [3:0]            al_be_lo;
   logic [3:0]            al_be_hi;
   logic [DATA_WIDTH-1:0] al_wdata_lo;
   logic [DATA_WIDTH-1:0] al_wdata_hi;
   logic [DATA_WIDTH-1:0] al_load;

   assign req_illegal = illegal_req(req_we_i, req_funct3_i) ||
                        (!SPLIT_MISAL && crosses_word(req_funct3_i[1:0], req_addr_i[1:0]));
   assign acc_cross   = crosses_word(funct3_q[1:0], addr_q[1:0]);
   assign word_hi     = addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);

   // The memory outputs are registered, so the first access cycle's lanes are
   // computed from the live request while idle; afterwards from the captured
   // request. Load data is merged on the edge that leaves the last access
   // state, so the final word comes straight from mem_rdata_i.
   always_comb begin
      al_funct3   = funct3_q;
      al_offset   = addr_q[1:0];
      al_wdata    = wdata_q;
      al_rdata_lo = '0;
      al_rdata_hi = '0;
      case (state)
         ST_IDLE: begin
            al_funct3 = req_funct3_i;
            al_offset = req_addr_i[1:0];
            al_wdata  = req_wdata_i;
         end
         ST_ACC_LO: begin
            al_rdata_lo = mem_rdata_i;
         end
         ST_ACC_HI: begin
            al_rdata_lo = rdata_lo_q;
            al_rdata_hi = mem_rdata_i;
         end
         default: begin
         end
      endcase
   end

   load_store_unit_data_align u_align (
      .funct3    (al_funct3),
      .offset    (al_offset),
      .wdata     (al_wdata),
      .rdata_lo  (al_rdata_lo),
      .rdata_hi  (al_rdata_hi),
      .be_lo     (al_be_lo),
      .be_hi     (al_be_hi),
      .wdata_lo  (al_wdata_lo),
      .wdata_hi  (al_wdata_hi),
      .load_data (al_load)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state        <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_lo_q   <= '0;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         mem_addr_o   <= '0;
         mem_be_o     <= '0;
         mem_we_o     <= 1'b0;
         mem_re_o     <= 1'b0;
         mem_wdata_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  funct3_q    <= req_funct3_i;
                  addr_q      <= req_addr_i;
                  wdata_q     <= req_wdata_i;
                  req_ready_o <= 1'b0;
                  if (req_illegal) begin
                     state        <= ST_RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                  end else begin
                     state       <= ST_ACC_LO;
                     mem_addr_o  <= req_addr_i[ADDR_WIDTH-1:2];
                     mem_be_o    <= al_be_lo;
                     mem_we_o    <= req_we_i;
                     mem_re_o    <= !req_we_i;
                     mem_wdata_o <= req_we_i ? al_wdata_lo : '0;
                  end
               end
            end

            ST_ACC_LO: begin
               rdata_lo_q <= mem_rdata_i;
               if (acc_cross) begin
                  state       <= ST_ACC_HI;
                  mem_addr_o  <= word_hi;
                  mem_be_o    <= al_be_hi;
                  mem_wdata_o <= we_q ? al_wdata_hi : '0;
               end else begin
                  state        <= ST_RESP;
                  mem_addr_o   <= '0;
                  mem_be_o     <= '0;
                  mem_we_o     <= 1'b0;
                  mem_re_o     <= 1'b0;
                  mem_wdata_o  <= '0;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b0;
                  resp_rdata_o <= we_q ? '0 : al_load;
               end
            end

            ST_ACC_HI: begin
               state        <= ST_RESP;
               mem_addr_o   <= '0;
               mem_be_o     <= '0;
               mem_we_o     <= 1'b0;
               mem_re_o     <= 1'b0;
               mem_wdata_o  <= '0;
               resp_valid_o <= 1'b1;
               resp_err_o   <= 1'b0;
               resp_rdata_o <= we_q ? '0 : al_load;
            end

            ST_RESP: begin
               // Ready rises only after the handshake, so a request cannot be
               // taken in the same cycle the response is consumed.
               if (resp_ready_i) begin
                  state        <= ST_IDLE;
                  resp_valid_o <= 1'b0;
                  resp_rdata_o <= '0;
                  resp_err_o   <= 1'b0;
                  req_ready_o  <= 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clock_i = 1'b0;
   logic        reset_ni;

   logic        req_valid_i, req_we_i, resp_ready_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        req_ready_o, resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o;
   logic [29:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic        mem_we_o, mem_re_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;

   logic        ns_req_valid, ns_resp_ready;
   logic [2:0]  ns_funct3;
   logic [31:0] ns_addr;
   logic        ns_req_ready, ns_resp_valid, ns_err;
   logic [31:0] ns_rdata;
   logic [29:0] ns_mem_addr;
   logic [3:0]  ns_mem_be;
   logic        ns_mem_we, ns_mem_re;
   logic [31:0] ns_mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock_i = ~clock_i;

   load_store_unit u_dut (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_we_o     (mem_we_o),
      .mem_re_o     (mem_re_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i)
   );

   load_store_unit #(.SPLIT_MISAL(1'b0)) u_dut_ns (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .req_valid_i  (ns_req_valid),
      .req_ready_o  (ns_req_ready),
      .req_we_i     (1'b0),
      .req_funct3_i (ns_funct3),
      .req_addr_i   (ns_addr),
      .req_wdata_i  (32'h0),
      .resp_valid_o (ns_resp_valid),
      .resp_ready_i (ns_resp_ready),
      .resp_rdata_o (ns_rdata),
      .resp_err_o   (ns_err),
      .mem_addr_o   (ns_mem_addr),
      .mem_be_o     (ns_mem_be),
      .mem_we_o     (ns_mem_we),
      .mem_re_o     (ns_mem_re),
      .mem_wdata_o  (ns_mem_wdata),
      .mem_rdata_i  (32'h0)
   );

   // Byte-enabled word memory: combinational read, write on the rising edge.
   logic [31:0] mem [256];
   logic        tb_clr;

   always @(posedge clock_i) begin
      if (tb_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_we_o) begin
         for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
   end
   assign mem_rdata_i = mem[mem_addr_o[7:0]];

   // Log of every memory access cycle.
   logic [29:0] log_addr  [64];
   logic [3:0]  log_be    [64];
   logic        log_we    [64];
   logic [31:0] log_wdata [64];
   int          log_n = 0;
   int          ns_strobes = 0;

   always @(posedge clock_i) begin
      if ((mem_we_o || mem_re_o) && log_n < 64) begin
         log_addr[log_n]  <= mem_addr_o;
         log_be[log_n]    <= mem_be_o;
         log_we[log_n]    <= mem_we_o;
         log_wdata[log_n] <= mem_wdata_o;
         log_n            <= log_n + 1;
      end
      if (ns_mem_we || ns_mem_re) ns_strobes <= ns_strobes + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_log(input string tag, input int idx, input logic [29:0] addr,
                          input logic [3:0] be, input logic we, input logic [31:0] wdata);
      check({tag, "_addr"},  32'(log_addr[idx]), 32'(addr));
      check({tag, "_be"},    32'(log_be[idx]),   32'(be));
      check({tag, "_we"},    32'(log_we[idx]),   32'(we));
      check({tag, "_wdata"}, log_wdata[idx],     wdata);
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int hold);
      int lat;
      bit got;
      @(negedge clock_i);
      check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      lat = 0;
      got = 0;
      while (!got && lat < 20) begin
         @(posedge clock_i);
         #1;
         lat++;
         req_valid_i = 1'b0;
         if (resp_valid_o) got = 1;
      end
      check({tag, "_lat"},   32'(lat),          32'(exp_lat));
      check({tag, "_rdata"}, resp_rdata_o,      exp_rdata);
      check({tag, "_err"},   32'(resp_err_o),   32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clock_i);
         #1;
         check({tag, "_hold_valid"}, 32'(resp_valid_o), 32'd1);
         check({tag, "_hold_rdata"}, resp_rdata_o,      exp_rdata);
         check({tag, "_hold_ready"}, 32'(req_ready_o),  32'd0);
      end
      resp_ready_i = 1'b1;
      @(posedge clock_i);
      #1;
      resp_ready_i = 1'b0;
      check({tag, "_done"}, 32'(resp_valid_o), 32'd0);
   endtask

   task automatic ns_do(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic exp_err, input int exp_lat);
      int lat;
      bit got;
      @(negedge clock_i);
      ns_req_valid = 1'b1;
      ns_funct3    = f3;
      ns_addr      = addr;
      lat = 0;
      got = 0;
      while (!got && lat < 20) begin
         @(posedge clock_i);
         #1;
         lat++;
         ns_req_valid = 1'b0;
         if (ns_resp_valid) got = 1;
      end
      check({tag, "_lat"},   32'(lat),    32'(exp_lat));
      check({tag, "_err"},   32'(ns_err), 32'(exp_err));
      check({tag, "_rdata"}, ns_rdata,    32'h0);
      ns_resp_ready = 1'b1;
      @(posedge clock_i);
      #1;
      ns_resp_ready = 1'b0;
   endtask

   int base;

   initial begin
      reset_ni      = 1'b1;
      tb_clr        = 1'b1;
      req_valid_i   = 1'b0;
      req_we_i      = 1'b0;
      req_funct3_i  = 3'b000;
      req_addr_i    = '0;
      req_wdata_i   = '0;
      resp_ready_i  = 1'b0;
      ns_req_valid  = 1'b0;
      ns_resp_ready = 1'b0;
      ns_funct3     = 3'b000;
      ns_addr       = '0;
      #1 reset_ni = 1'b0;
      #2;
      check("rst_ready",  32'(req_ready_o),  32'd1);
      check("rst_rvalid", 32'(resp_valid_o), 32'd0);
      check("rst_rdata",  resp_rdata_o,      32'h0);
      check("rst_err",    32'(resp_err_o),   32'd0);
      check("rst_we",     32'(mem_we_o),     32'd0);
      check("rst_re",     32'(mem_re_o),     32'd0);
      check("rst_be",     32'(mem_be_o),     32'd0);
      check("rst_addr",   32'(mem_addr_o),   32'd0);
      check("rst_wdata",  mem_wdata_o,       32'h0);
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      reset_ni = 1'b1;
      tb_clr   = 1'b0;

      base = log_n;
      do_req("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
      check("sw_100_nacc", 32'(log_n - base), 32'd1);
      chk_log("sw_100", base, 30'h40, 4'b1111, 1'b1, 32'hDEADBEEF);

      base = log_n;
      do_req("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
      chk_log("lw_100", base, 30'h40, 4'b1111, 1'b0, 32'h0);

      base = log_n;
      do_req("sb_103", 1'b1, 3'b000, 32'h103, 32'h80, 32'h0, 1'b0, 2, 0);
      chk_log("sb_103", base, 30'h40, 4'b1000, 1'b1, 32'h80000000);
      do_req("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
      do_req("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 2, 0);

      base = log_n;
      do_req("sw_102", 1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 1'b0, 3, 0);
      check("sw_102_nacc", 32'(log_n - base), 32'd2);
      chk_log("sw_102_lo", base,     30'h40, 4'b1100, 1'b1, 32'h33440000);
      chk_log("sw_102_hi", base + 1, 30'h41, 4'b0011, 1'b1, 32'h00001122);
      do_req("lw_102",  1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1'b0, 3, 0);
      do_req("lh_100",  1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0);
      do_req("lh_101",  1'b0, 3'b001, 32'h101, 32'h0, 32'h000044BE, 1'b0, 2, 0);
      do_req("lh_103",  1'b0, 3'b001, 32'h103, 32'h0, 32'h00002233, 1'b0, 3, 0);
      do_req("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, 2, 0);

      base = log_n;
      do_req("err_f3",  1'b0, 3'b011, 32'h100, 32'h0,  32'h0, 1'b1, 1, 0);
      do_req("err_sbu", 1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1'b1, 1, 0);
      check("err_nacc", 32'(log_n - base), 32'd0);

      do_req("hold_lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'h3344BEEF, 1'b0, 2, 5);

      base = log_n;
      do_req("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0, 1'b0, 3, 0);
      chk_log("sw_wrap_lo", base,     30'h3FFFFFFF, 4'b1100, 1'b1, 32'hF00D0000);
      chk_log("sw_wrap_hi", base + 1, 30'h0,        4'b0011, 1'b1, 32'h0000CAFE);
      do_req("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0);

      // Reset while the high half of a split store is on the port.
      @(negedge clock_i);
      req_valid_i  = 1'b1;
      req_we_i     = 1'b1;
      req_funct3_i = 3'b010;
      req_addr_i   = 32'h10A;
      req_wdata_i  = 32'hAABBCCDD;
      @(posedge clock_i);
      #1;
      req_valid_i = 1'b0;
      check("mid_lo_we",   32'(mem_we_o),   32'd1);
      check("mid_lo_addr", 32'(mem_addr_o), 32'h42);
      @(posedge clock_i);
      #1;
      check("mid_hi_we",   32'(mem_we_o),   32'd1);
      check("mid_hi_addr", 32'(mem_addr_o), 32'h43);
      check("mid_hi_be",   32'(mem_be_o),   32'b0011);
      #1 reset_ni = 1'b0;
      #1;
      check("mid_rst_we",    32'(mem_we_o),     32'd0);
      check("mid_rst_be",    32'(mem_be_o),     32'd0);
      check("mid_rst_ready", 32'(req_ready_o),  32'd1);
      check("mid_rst_valid", 32'(resp_valid_o), 32'd0);
      @(negedge clock_i);
      reset_ni = 1'b1;
      check("mid_lo_mem", mem[8'h42], 32'hCCDD0000);
      check("mid_hi_mem", mem[8'h43], 32'h0);
      do_req("lw_after_rst", 1'b0, 3'b010, 32'h108, 32'h0, 32'hCCDD0000, 1'b0, 2, 0);

      ns_do("ns_lh_0ff", 3'b001, 32'h0FF, 1'b1, 1);
      check("ns_no_strobe", 32'(ns_strobes), 32'd0);
      ns_do("ns_lw_100", 3'b010, 32'h100, 1'b0, 2);
      check("ns_one_strobe", 32'(ns_strobes), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
